// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
//
// Start/stop control FSM for a stopwatch counter datapath. A single start/stop
// pushbutton is turned into two level outputs. Each action fires once per full
// press-and-release, so holding the button never toggles the run state.
//
// Ports:
//   clk             in  1  system clock, all state changes on the rising edge
//   resetButton     in  1  synchronous active-low reset, forces INIT
//   startStopButton in  1  start/stop pushbutton, active-high, async to clk
//   reset           out 1  counter clear request, high only in INIT
//   cnt             out 1  counter enable, high only in COUNT
//
// Interface note: there is no handshake here. reset and cnt are plain levels
// that the counter datapath samples every cycle.
//
// Parameters:
//   SYNC_STAGES  flops in the startStopButton synchroniser (>= 1)
// -----------------------------------------------------------------------------
module stopwatch_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetButton,
  input  logic startStopButton,
  output logic reset,
  output logic cnt
);

  typedef enum logic [2:0] {
    INIT               = 3'd0,
    WAIT_RELEASE       = 3'd1,
    COUNT              = 3'd2,
    PAUSE              = 3'd3,
    PAUSE_WAIT_PRESS   = 3'd4,
    PAUSE_WAIT_RELEASE = 3'd5
  } state_t;

  // State register and its decoded outputs live together so a checker can
  // bind to ctrl_q.state and see exactly what drives reset/cnt.
  typedef struct packed {
    state_t state;
    logic   reset;
    logic   cnt;
  } ctrl_t;

  ctrl_t                  ctrl_q;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ssb_s;

  // Synchroniser chain; stage 0 samples the raw button.
  always_ff @(posedge clk) begin
    if (!resetButton) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= startStopButton;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign ssb_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_next = ctrl_q.state;
    case (ctrl_q.state)
      INIT:               if (ssb_s)  state_next = WAIT_RELEASE;
      WAIT_RELEASE:       if (!ssb_s) state_next = COUNT;
      COUNT:              if (ssb_s)  state_next = PAUSE;
      PAUSE:              if (!ssb_s) state_next = PAUSE_WAIT_PRESS;
      PAUSE_WAIT_PRESS:   if (ssb_s)  state_next = PAUSE_WAIT_RELEASE;
      PAUSE_WAIT_RELEASE: if (!ssb_s) state_next = COUNT;
      default:                        state_next = INIT;
    endcase
  end

  // Outputs are registered from the next state, so they are glitch-free Moore
  // levels that change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!resetButton) begin
      ctrl_q.state <= INIT;
      ctrl_q.reset <= 1'b1;
      ctrl_q.cnt   <= 1'b0;
    end else begin
      ctrl_q.state <= state_next;
      ctrl_q.reset <= (state_next == INIT);
      ctrl_q.cnt   <= (state_next == COUNT);
    end
  end

  assign reset = ctrl_q.reset;
  assign cnt   = ctrl_q.cnt;

endmodule

// File: tb/tb_stopwatch_controller.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_controller
//
// Directed bench for stopwatch_controller (default SYNC_STAGES = 2, so a
// button level change shows on the outputs on the 3rd rising edge).
// The driver applies inputs on the falling edge and pushes the hand-computed
// {reset, cnt} expected after the next rising edge; a monitor pops and
// compares 1 time unit after every rising edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_controller;

  logic clk;
  logic resetButton;
  logic startStopButton;
  logic reset;
  logic cnt;

  logic [1:0] exp_q[$];
  int         n_cmp;
  int         n_bad;
  int         cycle;

  stopwatch_controller #(.SYNC_STAGES(2)) dut (
    .clk             (clk),
    .resetButton     (resetButton),
    .startStopButton (startStopButton),
    .reset           (reset),
    .cnt             (cnt)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: time limit reached with %0d expected entries pending", exp_q.size());
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- driver tasks
  // n cycles at constant inputs, constant expected outputs
  task automatic hold(input logic rb, input logic ssb, input int n,
                      input logic er, input logic ec);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      resetButton     = rb;
      startStopButton = ssb;
      exp_q.push_back({er, ec});
    end
  endtask

  // New button level with resetButton released: outputs keep their old
  // values for two edges and take the new ones from the 3rd edge onward.
  task automatic phase(input logic ssb, input int n,
                       input logic br, input logic bc,
                       input logic ar, input logic ac);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      resetButton     = 1'b1;
      startStopButton = ssb;
      if (i >= 3) exp_q.push_back({ar, ac});
      else        exp_q.push_back({br, bc});
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(posedge clk) begin
    cycle <= cycle + 1;
    #1;
    if (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({reset, cnt} !== e) begin
        n_bad++;
        $display("FAIL outputs @cycle %0d: got reset=%b cnt=%b, expected reset=%b cnt=%b",
                 cycle, reset, cnt, e[1], e[0]);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_cmp = 0;
    n_bad = 0;
    cycle = 0;
    resetButton     = 1'b0;
    startStopButton = 1'b0;

    // 1: power-up reset, then idle in INIT
    hold(1'b0, 1'b0, 2, 1'b1, 1'b0);
    hold(1'b1, 1'b0, 5, 1'b1, 1'b0);

    // 2: press -> WAIT_RELEASE, release -> COUNT
    phase(1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    phase(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: pause cycle, reset never pulses
    phase(1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);   // PAUSE
    phase(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0);   // PAUSE_WAIT_PRESS
    phase(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);   // PAUSE_WAIT_RELEASE
    phase(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1);   // COUNT

    // 4: reset in COUNT takes effect on the first edge, then restart
    hold(1'b0, 1'b0, 5, 1'b1, 1'b0);
    phase(1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    phase(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: long hold in WAIT_RELEASE
    hold(1'b0, 1'b0, 2, 1'b1, 1'b0);
    phase(1'b1, 50, 1'b1, 1'b0, 1'b0, 1'b0);
    phase(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6: reset while held in PAUSE_WAIT_RELEASE, restart with button held
    phase(1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);   // PAUSE
    phase(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0);   // PAUSE_WAIT_PRESS
    phase(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);   // PAUSE_WAIT_RELEASE
    hold(1'b0, 1'b1, 3, 1'b1, 1'b0);          // INIT, synchroniser cleared
    phase(1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0);   // WAIT_RELEASE, not COUNT
    phase(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1);   // COUNT on release

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name:
stopwatch_controller

Overview:
- Start/stop control FSM for a stopwatch/counter datapath.
- Turns a single start/stop pushbutton into two level outputs:
  - reset: holds the counter at zero.
  - cnt: lets the counter advance.
- Each action triggers once per full press-and-release, so holding the button never toggles the run state repeatedly.
- Sits between the board button inputs and the counter/display datapath.

Parameters:
- SYNC_STAGES, 2: number of flip-flop stages synchronising startStopButton into the clk domain. Legal values are 1 or more.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- resetButton, input, 1: synchronous active-low reset. Sampled on the rising clk edge; low forces the FSM to INIT.
- startStopButton, input, 1: start/stop pushbutton, active-high, asynchronous to clk.
- reset, output, 1: counter clear request, active-high.
- cnt, output, 1: counter enable, active-high.

Behaviour:
- Reset:
  - While resetButton=0 at a rising edge: state<=INIT and all synchroniser flops<=0.
  - Reset overrides any button activity, in every state, including mid-count and mid-pause.
  - Outputs after reset: reset=1, cnt=0.
- Synchroniser:
  - startStopButton passes through a chain of SYNC_STAGES flops. Call the last stage ssb_s.
  - The FSM sees only ssb_s.
  - A level change on startStopButton reaches ssb_s after SYNC_STAGES edges. The state changes on the following edge.
  - With the default, the total is 3 rising edges.
- States (6, binary-encoded, registered) and transitions on ssb_s:
  - INIT: ssb_s=1 -> WAIT_RELEASE; otherwise stay.
  - WAIT_RELEASE: ssb_s=0 -> COUNT; otherwise stay.
  - COUNT: ssb_s=1 -> PAUSE; otherwise stay.
  - PAUSE (stop pressed, waiting for release): ssb_s=0 -> PAUSE_WAIT_PRESS; otherwise stay.
  - PAUSE_WAIT_PRESS: ssb_s=1 -> PAUSE_WAIT_RELEASE; otherwise stay.
  - PAUSE_WAIT_RELEASE: ssb_s=0 -> COUNT; otherwise stay.
  - Unused encodings -> INIT on the next edge.
- Outputs (Moore, decoded from the state register only, glitch-free):
  - reset=1 only in INIT; 0 elsewhere.
  - cnt=1 only in COUNT; 0 elsewhere.
  - reset and cnt are never both 1.
- Hold behaviour:
  - Holding the button in any WAIT/PAUSE state holds that state indefinitely.
  - Counting resumes or begins only on release, never on press.
- Pause preserves the count:
  - Going from pause back to count does not pass through INIT, so reset stays 0.
  - Only resetButton low clears the count.
- Bounce: no debounce filtering is performed. Each stable level lasting at least SYNC_STAGES+1 cycles is acted on.

Test Plan:
1. Power-up with resetButton=0 for 2 cycles, startStopButton=0, then resetButton=1 -> reset=1, cnt=0, state INIT. Both outputs hold for 5 idle cycles.
2. From INIT, press startStopButton for 5 cycles -> reset falls to 0 exactly 3 edges after the press; cnt stays 0. Release for 5 cycles -> cnt=1 exactly 3 edges after release (COUNT).
3. In COUNT, press 5 cycles -> cnt=0 3 edges after press; reset stays 0. Release -> still cnt=0. Press -> still cnt=0. Release -> cnt=1 3 edges after release, and reset never pulses during the sequence.
4. In COUNT, drive resetButton=0 for 5 cycles -> on the first edge with it low, reset=1 and cnt=0. After resetButton=1, a press/release sequence gives cnt=1 again.
5. In WAIT_RELEASE, hold startStopButton=1 for 50 cycles -> cnt=0 and reset=0 throughout. On release -> cnt=1 3 edges later.
6. Assert resetButton=0 while startStopButton=1 in PAUSE_WAIT_RELEASE -> INIT (reset=1). With the button still held after resetButton=1 -> WAIT_RELEASE, not COUNT; cnt=0 until release.
